// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller and the datapath mux selects.
// MIPS_CTRL_BNE_EN adds the BRNE state and opcode 0x05 support.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_JUMP   = 4'd12
`ifdef MIPS_CTRL_BNE_EN
      , S_BRNE = 4'd13
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] ALUB_RT     = 2'b00;
   localparam logic [1:0] ALUB_FOUR   = 2'b01;
   localparam logic [1:0] ALUB_IMM    = 2'b10;
   localparam logic [1:0] ALUB_IMMSH2 = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-output decoder for the multicycle MIPS controller.
// MIPS_CTRL_BNE_EN enables decoding of the BRNE state.
module mips_ctrl_outdec
   import mips_ctrl_pkg::*;
(
   input  logic [3:0] i_state,
   input  logic       i_memReady,
   input  logic       i_zero,
   input  logic       i_opIllegal,
   output logic       o_memReq,
   output logic       o_memWrite,
   output logic       o_iord,
   output logic       o_irWrite,
   output logic       o_regDst,
   output logic       o_memToReg,
   output logic       o_regWrite,
   output logic       o_aluSrcA,
   output logic [1:0] o_aluSrcB,
   output logic [1:0] o_aluOp,
   output logic [1:0] o_pcSrc,
   output logic       o_pcEn,
   output logic       o_illegalOp
);

   // Every output defaults low so RESET and unused encodings are inert.
   always_comb begin
      o_memReq    = 1'b0;
      o_memWrite  = 1'b0;
      o_iord      = 1'b0;
      o_irWrite   = 1'b0;
      o_regDst    = 1'b0;
      o_memToReg  = 1'b0;
      o_regWrite  = 1'b0;
      o_aluSrcA   = 1'b0;
      o_aluSrcB   = ALUB_RT;
      o_aluOp     = ALUOP_ADD;
      o_pcSrc     = PC_ALU;
      o_pcEn      = 1'b0;
      o_illegalOp = 1'b0;
      case (i_state)
         S_FETCH: begin
            o_memReq  = 1'b1;
            o_aluSrcB = ALUB_FOUR;
            o_irWrite = i_memReady;
            o_pcEn    = i_memReady;
         end
         S_DECODE: begin
            o_aluSrcB   = ALUB_IMMSH2;
            o_illegalOp = i_opIllegal;
         end
         S_MEMADR, S_ADDIEX: begin
            o_aluSrcA = 1'b1;
            o_aluSrcB = ALUB_IMM;
         end
         S_MEMRD: begin
            o_memReq = 1'b1;
            o_iord   = 1'b1;
         end
         S_MEMWB: begin
            o_memToReg = 1'b1;
            o_regWrite = 1'b1;
         end
         S_MEMWR: begin
            o_memReq   = 1'b1;
            o_memWrite = 1'b1;
            o_iord     = 1'b1;
         end
         S_EXEC: begin
            o_aluSrcA = 1'b1;
            o_aluOp   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            o_regDst   = 1'b1;
            o_regWrite = 1'b1;
         end
         S_BRANCH: begin
            o_aluSrcA = 1'b1;
            o_aluOp   = ALUOP_SUB;
            o_pcSrc   = PC_ALUOUT;
            o_pcEn    = i_zero;
         end
`ifdef MIPS_CTRL_BNE_EN
         S_BRNE: begin
            o_aluSrcA = 1'b1;
            o_aluOp   = ALUOP_SUB;
            o_pcSrc   = PC_ALUOUT;
            o_pcEn    = !i_zero;
         end
`endif
         S_ADDIWB: o_regWrite = 1'b1;
         S_JUMP: begin
            o_pcSrc = PC_JUMP;
            o_pcEn  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main controller: state register, next-state logic, output decoder.
// MIPS_CTRL_BNE_EN adds bne (opcode 0x05) via the BRNE state.
module mips_mc_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int OPW = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [OPW-1:0] op,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           mem_req,
   output logic           memwrite,
   output logic           iord,
   output logic           irwrite,
   output logic           regdst,
   output logic           memtoreg,
   output logic           regwrite,
   output logic           alusrca,
   output logic [1:0]     alusrcb,
   output logic [1:0]     aluop,
   output logic [1:0]     pcsrc,
   output logic           pc_en,
   output logic           illegal_op,
   output logic [3:0]     state_o
);

   state_t r_state;
   state_t w_decNext;
   logic   w_opIllegal;

   always_comb begin
      w_decNext   = S_FETCH;
      w_opIllegal = 1'b0;
      case (op)
         OPW'(OP_LW), OPW'(OP_SW): w_decNext = S_MEMADR;
         OPW'(OP_RTYPE):           w_decNext = S_EXEC;
         OPW'(OP_BEQ):             w_decNext = S_BRANCH;
         OPW'(OP_ADDI):            w_decNext = S_ADDIEX;
         OPW'(OP_J):               w_decNext = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
         OPW'(OP_BNE):             w_decNext = S_BRNE;
`endif
         default:                  w_opIllegal = 1'b1;
      endcase
   end

   // Only the memory states wait on mem_ready; every terminal state returns to FETCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RESET;
      end else begin
         case (r_state)
            S_RESET:  r_state <= S_FETCH;
            S_FETCH:  if (mem_ready) r_state <= S_DECODE;
            S_DECODE: r_state <= w_decNext;
            S_MEMADR: r_state <= (op == OPW'(OP_LW)) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
            S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
            S_EXEC:   r_state <= S_ALUWB;
            S_ADDIEX: r_state <= S_ADDIWB;
            default:  r_state <= S_FETCH;
         endcase
      end
   end

   assign state_o = r_state;

   mips_ctrl_outdec u_outdec (
      .i_state     (r_state),
      .i_memReady  (mem_ready),
      .i_zero      (zero),
      .i_opIllegal (w_opIllegal),
      .o_memReq    (mem_req),
      .o_memWrite  (memwrite),
      .o_iord      (iord),
      .o_irWrite   (irwrite),
      .o_regDst    (regdst),
      .o_memToReg  (memtoreg),
      .o_regWrite  (regwrite),
      .o_aluSrcA   (alusrca),
      .o_aluSrcB   (alusrcb),
      .o_aluOp     (aluop),
      .o_pcSrc     (pcsrc),
      .o_pcEn      (pc_en),
      .o_illegalOp (illegal_op)
   );

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Testbench for mips_mc_ctrl: instruction-level phase model compared each cycle.
// Honours MIPS_CTRL_BNE_EN for the expected handling of opcode 0x05.
module tb_mips_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic       pc_en, illegal_op;
   logic [3:0] state_o;

   int errors = 0;
   int checks = 0;

   // Instruction phases as seen from the programmer's view, not DUT state codes.
   typedef enum int {P_RST, P_FETCH, P_DEC, P_ADDR, P_LOAD, P_LOADWB, P_STORE,
                     P_RALU, P_RWB, P_BEQ, P_BNE, P_IALU, P_IWB, P_JMP} phase_t;
   typedef phase_t phaseQ_t[$];

   mips_mc_ctrl #(.OPW(6)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
      .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
      .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pc_en(pc_en),
      .illegal_op(illegal_op), .state_o(state_o)
   );

   always #5 clk = ~clk;

   function automatic phaseQ_t buildSeq(input logic [5:0] opc);
      phaseQ_t q;
      q.push_back(P_FETCH);
      q.push_back(P_DEC);
      case (opc)
         6'h23: begin q.push_back(P_ADDR); q.push_back(P_LOAD); q.push_back(P_LOADWB); end
         6'h2B: begin q.push_back(P_ADDR); q.push_back(P_STORE); end
         6'h00: begin q.push_back(P_RALU); q.push_back(P_RWB); end
         6'h04: q.push_back(P_BEQ);
         6'h08: begin q.push_back(P_IALU); q.push_back(P_IWB); end
         6'h02: q.push_back(P_JMP);
`ifdef MIPS_CTRL_BNE_EN
         6'h05: q.push_back(P_BNE);
`endif
         default: ;
      endcase
      return q;
   endfunction

   function automatic bit isLegal(input logic [5:0] opc);
`ifdef MIPS_CTRL_BNE_EN
      if (opc == 6'h05) return 1'b1;
`endif
      return opc inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
   endfunction

   // Packed as {mem_req,memwrite,iord,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,aluop,pcsrc,pc_en,illegal_op}.
   function automatic logic [15:0] expOut(input phase_t p, input logic mr, input logic z,
                                          input logic [5:0] opc);
      logic mreq = 0, mw = 0, io = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, pe = 0, ill = 0;
      logic [1:0] sb = 2'b00, ao = 2'b00, ps = 2'b00;
      case (p)
         P_FETCH:  begin mreq = 1; sb = 2'b01; irw = mr; pe = mr; end
         P_DEC:    begin sb = 2'b11; ill = !isLegal(opc); end
         P_ADDR:   begin sa = 1; sb = 2'b10; end
         P_LOAD:   begin mreq = 1; io = 1; end
         P_LOADWB: begin m2r = 1; rw = 1; end
         P_STORE:  begin mreq = 1; mw = 1; io = 1; end
         P_RALU:   begin sa = 1; ao = 2'b10; end
         P_RWB:    begin rd = 1; rw = 1; end
         P_BEQ:    begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
         P_BNE:    begin sa = 1; ao = 2'b01; ps = 2'b01; pe = !z; end
         P_IALU:   begin sa = 1; sb = 2'b10; end
         P_IWB:    rw = 1;
         P_JMP:    begin ps = 2'b10; pe = 1; end
         default:  ;
      endcase
      return {mreq, mw, io, irw, rd, m2r, rw, sa, sb, ao, ps, pe, ill};
   endfunction

   task automatic applyStimulus(input logic [5:0] opc, input logic mr, input logic z);
      @(negedge clk);
      op = opc;
      mem_ready = mr;
      zero = z;
      #1;
   endtask

   task automatic checkOutput(input phase_t p, input logic mr, input logic z,
                              input logic [5:0] opc, input string tag);
      logic [15:0] obs, exp;
      obs = {mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, aluop, pcsrc, pc_en, illegal_op};
      exp = expOut(p, mr, z, opc);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s outputs phase=%s op=%h observed=%h expected=%h",
                tag, p.name(), opc, obs, exp);
      end
      checks++;
      assert ((state_o == 4'd0) === (p == P_RST)) else begin
         errors++;
         $error("[TB] FAIL %s state_o phase=%s observed=%0d expected_reset=%0d",
                tag, p.name(), state_o, (p == P_RST));
      end
   endtask

   // Runs one instruction; FETCH stalls fStall cycles, data access stalls mStall cycles.
   task automatic runInstr(input logic [5:0] opc, input int fStall, input int mStall,
                           input logic z, input bit abortWb, input string tag);
      phaseQ_t q;
      phase_t  p;
      int      stalls;
      int      limit;
      bit      isMem;
      logic    rdy;
      q = buildSeq(opc);
      stalls = 0;
      while (q.size() > 0) begin
         p = q[0];
         isMem = (p == P_FETCH) || (p == P_LOAD) || (p == P_STORE);
         limit = (p == P_FETCH) ? fStall : mStall;
         rdy = isMem ? (stalls >= limit) : 1'($urandom_range(0, 1));
         applyStimulus(opc, rdy, z);
         checkOutput(p, rdy, z, opc, tag);
         if (abortWb && p == P_RWB) begin
            #2 rst_n = 1'b0;
            #1 checkOutput(P_RST, rdy, z, opc, {tag, "_async"});
            @(negedge clk);
            rst_n = 1'b1;
            #1 checkOutput(P_RST, rdy, z, opc, {tag, "_release"});
            q.delete();
         end else if (isMem && !rdy) begin
            stalls++;
         end else begin
            void'(q.pop_front());
            stalls = 0;
         end
      end
   endtask

   initial begin
      logic [5:0] opList [9];
      logic [5:0] opc;
      opList = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h05, 6'h3F, 6'h11};
      rst_n = 1'b0;
      op = 6'h00;
      zero = 1'b0;
      mem_ready = 1'b1;
      applyStimulus(6'h00, 1'b1, 1'b0);
      checkOutput(P_RST, 1'b1, 1'b0, 6'h00, "reset_hold");
      applyStimulus(6'h00, 1'b1, 1'b0);
      rst_n = 1'b1;
      #1 checkOutput(P_RST, 1'b1, 1'b0, 6'h00, "reset_release");

      runInstr(6'h23, 3, 0, 1'b0, 1'b0, "lw_fetch_stall");
      runInstr(6'h04, 0, 0, 1'b1, 1'b0, "beq_taken");
      runInstr(6'h04, 0, 0, 1'b0, 1'b0, "beq_not_taken");
      runInstr(6'h2B, 0, 2, 1'b0, 1'b0, "sw_mem_stall");
      runInstr(6'h3F, 0, 0, 1'b0, 1'b0, "illegal_3f");
      runInstr(6'h05, 0, 0, 1'b0, 1'b0, "op05_z0");
      runInstr(6'h05, 0, 0, 1'b1, 1'b0, "op05_z1");
      runInstr(6'h00, 0, 0, 1'b0, 1'b1, "rtype_reset_wb");
      runInstr(6'h08, 0, 0, 1'b0, 1'b0, "addi");
      runInstr(6'h02, 0, 0, 1'b0, 1'b0, "jump");
      runInstr(6'h23, 0, 3, 1'b1, 1'b0, "lw_mem_stall");

      for (int i = 0; i < 80; i++) begin
         opc = opList[$urandom_range(0, 8)];
         if (opc == 6'h11) opc = 6'($urandom_range(0, 63));
         runInstr(opc, $urandom_range(0, 2), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'b0, "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
